// File: rtl/adc_cap_pkg.sv
// Shared types and constants for the ADC pre-trigger capture engine.
package adc_cap_pkg;

  // Capture controller states.
  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StPost,
    StDone
  } cap_state_e;

  // Values of mode_i, sampled when a capture is armed.
  localparam logic MODE_IMMEDIATE = 1'b0;
  localparam logic MODE_TRIGGERED = 1'b1;

endpackage

// File: rtl/adc_word_packer.sv
// Packs RATIO consecutive valid stream beats into one wide word. The first
// beat lands in the low lane. A completed word and its strobe are registered.
module adc_word_packer #(
  parameter int unsigned DWIDTH_IN = 128,
  parameter int unsigned RATIO     = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [DWIDTH_IN-1:0]       tdata_i,
  input  logic                       tvalid_i,
  input  logic                       align_i,
  output logic [DWIDTH_IN*RATIO-1:0] word_o,
  output logic                       word_valid_o
);

  localparam int unsigned LaneBits = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LaneBits-1:0] LastLane = LaneBits'(RATIO - 1);

  logic [LaneBits-1:0]       lane_q, lane_d;
  logic [DWIDTH_IN*RATIO-1:0] data_q, data_d;
  logic [DWIDTH_IN*RATIO-1:0] word_q, word_d;
  logic                       word_valid_q, word_valid_d;

  // Lane steering; align drops the current beat and any word in flight.
  always_comb begin
    lane_d       = lane_q;
    data_d       = data_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (align_i) begin
      lane_d = '0;
    end else if (tvalid_i) begin
      data_d[lane_q*DWIDTH_IN +: DWIDTH_IN] = tdata_i;
      if (lane_q == LastLane) begin
        word_d       = data_d;
        word_valid_d = 1'b1;
        lane_d       = '0;
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end
  end

  // Packer state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q       <= '0;
      data_q       <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      data_q       <= data_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;

endmodule

// File: rtl/adc_cap_pretrig.sv
// ADC snapshot engine: packs stream beats into BRAM words and captures
// MAX_XFER words either immediately or around a trigger with a programmable
// pre-trigger depth, using the BRAM as a circular buffer.
module adc_cap_pretrig
  import adc_cap_pkg::*;
#(
  parameter int unsigned DWIDTH_IN  = 128,
  parameter int unsigned RATIO      = 2,
  parameter int unsigned DWIDTH_OUT = DWIDTH_IN * RATIO,
  parameter int unsigned MAX_XFER   = 2048,
  parameter int unsigned ADDR_BITS  = $clog2(MAX_XFER)
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [DWIDTH_IN-1:0]    s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    capture_i,
  input  logic                    mode_i,
  input  logic [ADDR_BITS-1:0]    pretrig_i,
  input  logic                    trig_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [ADDR_BITS-1:0]    start_addr_o,
  output logic [DWIDTH_OUT-1:0]   bram_wdata,
  output logic [DWIDTH_OUT/8-1:0] bram_we,
  output logic                    bram_en,
  input  logic [DWIDTH_OUT-1:0]   bram_rdata,
  output logic [31:0]             bram_addr,
  output logic                    bram_clk,
  output logic                    bram_rst
);

  localparam logic [ADDR_BITS:0] XferWords = (ADDR_BITS + 1)'(MAX_XFER);
  localparam logic [ADDR_BITS:0] OneWord   = (ADDR_BITS + 1)'(1);

  cap_state_e           state_q, state_d;
  logic                 cap_q;
  logic                 arm;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_BITS-1:0] pretrig_q, pretrig_d;
  logic [ADDR_BITS-1:0] start_addr_q, start_addr_d;
  logic [ADDR_BITS:0]   remaining_q, remaining_d;
  logic [ADDR_BITS:0]   rem_cur;
  logic [DWIDTH_OUT-1:0] word;
  logic                 word_valid;
  logic                 unused_rdata;

  // Capture edge detector; edges outside IDLE/DONE are ignored.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cap_q <= 1'b0;
    end else begin
      cap_q <= capture_i;
    end
  end

  assign arm   = capture_i & ~cap_q & ((state_q == StIdle) | (state_q == StDone));
  assign wr_en = word_valid & ((state_q == StArmed) | (state_q == StPost));

  adc_word_packer #(
    .DWIDTH_IN (DWIDTH_IN),
    .RATIO     (RATIO)
  ) u_packer (
    .clk_i        (aclk),
    .rst_i        (areset),
    .tdata_i      (s_axis_tdata),
    .tvalid_i     (s_axis_tvalid),
    .align_i      (arm),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  // Capture FSM next-state: arming, trigger qualification and the post count.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    pre_cnt_d    = pre_cnt_q;
    pretrig_d    = pretrig_q;
    start_addr_d = start_addr_q;
    remaining_d  = remaining_q;
    rem_cur      = remaining_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    unique case (state_q)
      StIdle, StDone: begin
        if (arm) begin
          wr_ptr_d     = '0;
          pre_cnt_d    = '0;
          start_addr_d = '0;
          pretrig_d    = pretrig_i;
          if (mode_i == MODE_TRIGGERED) begin
            state_d = StArmed;
          end else begin
            remaining_d = XferWords;
            state_d     = StPost;
          end
        end
      end
      StArmed: begin
        if (wr_en && (pre_cnt_q < pretrig_q)) begin
          pre_cnt_d = pre_cnt_q + 1'b1;
        end
        if (trig_i && (pre_cnt_q >= pretrig_q)) begin
          start_addr_d = wr_ptr_q - pretrig_q;
          rem_cur      = XferWords - {1'b0, pretrig_q};
          remaining_d  = rem_cur;
          state_d      = StPost;
          // A write in the accept cycle is already a post-trigger word.
          if (wr_en) begin
            remaining_d = rem_cur - OneWord;
            if (rem_cur == OneWord) begin
              state_d = StDone;
            end
          end
        end
      end
      StPost: begin
        if (wr_en) begin
          remaining_d = remaining_q - OneWord;
          if (remaining_q == OneWord) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Capture FSM state registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      pre_cnt_q    <= '0;
      pretrig_q    <= '0;
      start_addr_q <= '0;
      remaining_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      pre_cnt_q    <= pre_cnt_d;
      pretrig_q    <= pretrig_d;
      start_addr_q <= start_addr_d;
      remaining_q  <= remaining_d;
    end
  end

  assign s_axis_tready = 1'b1;
  assign busy_o        = (state_q == StArmed) | (state_q == StPost);
  assign done_o        = (state_q == StDone);
  assign start_addr_o  = start_addr_q;
  assign bram_wdata    = word;
  assign bram_we       = {(DWIDTH_OUT / 8){wr_en}};
  assign bram_en       = wr_en;
  assign bram_addr     = 32'(wr_ptr_q);
  assign bram_clk      = aclk;
  assign bram_rst      = areset;
  assign unused_rdata  = ^bram_rdata;

endmodule

// File: tb/tb_adc_cap_pretrig.sv
// Bench for adc_cap_pretrig: directed captures, a per-cycle behavioural model
// and hand-computed expectations for the captured buffer contents.
module tb_adc_cap_pretrig;

  localparam int unsigned DW = 16;
  localparam int unsigned NW = 16;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          capture_i = 1'b0;
  logic          mode_i = 1'b0;
  logic [3:0]    pretrig_i = '0;
  logic          trig_i = 1'b0;
  logic          busy_o, done_o;
  logic [3:0]    start_addr_o;
  logic [31:0]   bram_wdata;
  logic [3:0]    bram_we;
  logic          bram_en;
  logic [31:0]   bram_rdata = '0;
  logic [31:0]   bram_addr;
  logic          bram_clk, bram_rst;

  adc_cap_pretrig #(
    .DWIDTH_IN (DW),
    .RATIO     (2),
    .MAX_XFER  (NW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .capture_i     (capture_i),
    .mode_i        (mode_i),
    .pretrig_i     (pretrig_i),
    .trig_i        (trig_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .start_addr_o  (start_addr_o),
    .bram_wdata    (bram_wdata),
    .bram_we       (bram_we),
    .bram_en       (bram_en),
    .bram_rdata    (bram_rdata),
    .bram_addr     (bram_addr),
    .bram_clk      (bram_clk),
    .bram_rst      (bram_rst)
  );

  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // BRAM image as written by the DUT, plus a running write count.
  logic [31:0] mem [NW];
  int          wr_total = 0;
  int          wr_base = 0;

  always @(posedge aclk) begin
    if (bram_en) begin
      mem[bram_addr[3:0]] <= bram_wdata;
      wr_total            <= wr_total + 1;
    end
  end

  function automatic int wcount();
    return wr_total - wr_base;
  endfunction

  // Behavioural model: phase 0 idle, 1 armed, 2 post, 3 done. Word count since
  // arm gives the address; trigger/done follow from write counts directly.
  int            m_phase = 0;
  bit            m_cap_prev = 1'b0;
  logic [DW-1:0] m_beats[$];
  bit            m_pend = 1'b0;
  logic [31:0]   m_pend_data = '0;
  int            m_writes = 0;
  int            m_pre = 0;
  int            m_post = 0;
  int            m_start = 0;
  bit            m_wr, m_arm;
  int            m_before;

  always @(negedge aclk) begin
    m_wr = m_pend && (m_phase == 1 || m_phase == 2);
    check("bram_en", bram_en, m_wr);
    check("bram_we", bram_we, m_wr ? 4'hf : 4'h0);
    if (m_wr) begin
      check("bram_addr", bram_addr, m_writes % NW);
      check("bram_wdata", bram_wdata, m_pend_data);
    end
    check("busy_o", busy_o, m_phase == 1 || m_phase == 2);
    check("done_o", done_o, m_phase == 3);
    check("start_addr_o", start_addr_o, m_start);
    if (areset) begin
      m_phase = 0; m_pend = 0; m_beats.delete(); m_writes = 0; m_start = 0;
      m_cap_prev = 0;
    end else begin
      m_arm = capture_i && !m_cap_prev && (m_phase == 0 || m_phase == 3);
      m_cap_prev = capture_i;
      if (m_arm) begin
        m_writes = 0; m_start = 0; m_post = 0;
        m_pre = mode_i ? int'(pretrig_i) : 0;
        m_phase = mode_i ? 1 : 2;
        m_beats.delete();
        m_pend = 0;
      end else begin
        m_before = m_writes;
        if (m_wr) m_writes++;
        if (m_phase == 1 && trig_i && m_before >= m_pre) begin
          m_start = (m_before - m_pre) % NW;
          m_phase = 2;
          m_post = m_wr ? 1 : 0;
        end else if (m_phase == 2 && m_wr) begin
          m_post++;
        end
        if (m_phase == 2 && m_post == NW - m_pre) m_phase = 3;
        m_pend = 0;
        if (s_axis_tvalid) begin
          m_beats.push_back(s_axis_tdata);
          if (m_beats.size() == 2) begin
            m_pend = 1;
            m_pend_data = {m_beats[1], m_beats[0]};
            m_beats.delete();
          end
        end
      end
    end
  end

  int beat = 0;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic arm(input bit mode, input int pre, input bit trig_high);
    capture_i = 1'b1;
    mode_i = mode;
    pretrig_i = 4'(pre);
    trig_i = trig_high;
    s_axis_tvalid = 1'b0;
    step();
    capture_i = 1'b0;
    wr_base = wr_total;
    beat = 0;
  endtask

  // trig_at: -1 keep trig high, -2 never trigger, else pulse at that write count
  // (optionally only in a cycle carrying a write strobe).
  task automatic run(input bit sparse, input int trig_at, input bit on_strobe,
                     input int edge_at, input int rst_at);
    int cyc = 0;
    bit fired = 0;
    bit edged = 0;
    int saved;
    while (!done_o && cyc < 400) begin
      if (rst_at >= 0 && wcount() == rst_at) begin
        areset = 1'b1;
        s_axis_tvalid = 1'b0;
        trig_i = 1'b0;
        step();
        areset = 1'b0;
        check("rst_bram_en", bram_en, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        saved = wcount();
        repeat (3) step();
        check("rst_no_write", wcount(), saved);
        return;
      end
      s_axis_tvalid = sparse ? ((cyc % 2) == 0) : 1'b1;
      if (s_axis_tvalid) begin
        s_axis_tdata = 16'(beat);
        beat++;
      end else begin
        s_axis_tdata = 16'hdead;
      end
      if (trig_at >= 0) begin
        trig_i = !fired && (wcount() == trig_at) && (!on_strobe || bram_en);
        if (trig_i) fired = 1;
      end else if (trig_at == -2) begin
        trig_i = 1'b0;
      end
      capture_i = (edge_at >= 0) && !edged && (wcount() == edge_at);
      if (capture_i) edged = 1;
      step();
      cyc++;
    end
    check("capture_done", done_o, 1);
    s_axis_tvalid = 1'b0;
    trig_i = 1'b0;
    capture_i = 1'b0;
    repeat (3) step();
  endtask

  task automatic ramp(input int s, input int base);
    for (int k = 0; k < NW; k++) begin
      logic [15:0] lo;
      lo = 16'(base + 2 * k);
      check("ramp_word", mem[(s + k) % NW], {lo + 16'd1, lo});
    end
  endtask

  initial begin
    repeat (3) step();
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_start", start_addr_o, 0);
    check("reset_en", bram_en, 0);
    check("reset_addr", bram_addr, 0);
    check("reset_wdata", bram_wdata, 0);
    check("reset_bram_rst", bram_rst, 1);
    check("tready", s_axis_tready, 1);
    check("bram_clk", bram_clk, 1);
    areset = 1'b0;
    step();

    // Immediate, continuous beats.
    arm(0, 0, 0);
    run(0, -2, 0, -1, -1);
    check("imm_count", wcount(), 16);
    check("imm_start", start_addr_o, 0);
    check("imm_w0", mem[0], 32'h0001_0000);
    check("imm_w15", mem[15], 32'h001f_001e);

    // Immediate, tvalid every other cycle.
    arm(0, 0, 0);
    run(1, -2, 0, -1, -1);
    check("sparse_count", wcount(), 16);
    check("sparse_w0", mem[0], 32'h0001_0000);
    check("sparse_w15", mem[15], 32'h001f_001e);

    // Triggered, pretrig 5, trigger held high from arm.
    arm(1, 5, 1);
    run(0, -1, 0, -1, -1);
    check("early_trig_start", start_addr_o, 0);
    check("early_trig_count", wcount(), 16);
    check("early_trig_w4", mem[4], 32'h0009_0008);
    check("early_trig_w5", mem[5], 32'h000b_000a);

    // Triggered, pretrig 5, trigger after 37 writes (wr_ptr 5).
    arm(1, 5, 0);
    run(0, 37, 0, -1, -1);
    check("trig37_start", start_addr_o, 0);
    check("trig37_count", wcount(), 48);
    ramp(0, 64);

    // Triggered, pretrig 5, trigger after 34 writes (wr_ptr 2).
    arm(1, 5, 0);
    run(0, 34, 0, -1, -1);
    check("trig34_start", start_addr_o, 13);
    check("trig34_count", wcount(), 45);
    ramp(13, 58);

    // Triggered, pretrig 0, trigger coincident with a write strobe.
    arm(1, 0, 0);
    run(0, 3, 1, -1, -1);
    check("coinc_start", start_addr_o, 3);
    check("coinc_count", wcount(), 19);
    check("coinc_w3", mem[3], 32'h0007_0006);
    check("coinc_w2", mem[2], 32'h0025_0024);

    // Capture edge during POST is ignored.
    arm(0, 0, 0);
    run(0, -2, 0, 5, -1);
    check("edge_ignored_count", wcount(), 16);
    check("edge_ignored_start", start_addr_o, 0);

    // Reset mid-POST.
    arm(0, 0, 0);
    run(0, -2, 0, -1, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
